hazard_sched: RTL and testbench
===============================

// Module: hazard_sched
// PURPOSE
//   Pipeline hazard scheduler for the 16-bit 5-stage core (F/D/E/M/W).
//   Drives the stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers.
//   Produces operand-forwarding selects for E.
//   Sequences load-use bubbles and branch flushes, and holds the pipe on multi-cycle data-memory accesses.
// PARAMETERS
//   LU_STALLS    1    bubbles inserted per load-use hazard (1..7)
//   MEM_TIMEOUT  15   max consecutive memory wait cycles before abort (1..255)
//   CNT_W        16   width of performance counters
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      synchronous, active-high
//   rs1D,rs2D    in   4      source regs of instr in D
//   useRs1D,useRs2D in 1     D instr reads rs1/rs2
//   rs1E,rs2E    in   4      source regs of instr in E
//   rdE          in   4      dest reg in E
//   regWriteE    in   1      E instr writes reg
//   resultSrcE   in   2      2'b01 = load result (memory)
//   branchTakenE in   1      taken branch/jump resolved in E
//   rdM,rdW      in   4      dest reg in M / W
//   regWriteM,regWriteW in 1 M / W instr writes reg
//   memReqM      in   1      M instr accesses data memory
//   memReadyM    in   1      data memory completes access this cycle
//   stallF,stallD,stallE,stallM out 1  hold stage register
//   flushD,flushE,flushW out 1         load bubble into stage register
//   forwardAE,forwardBE out 2          00 regfile, 01 from W, 10 from M
//   memErr       out  1      sticky: memory timeout occurred
//   stallCnt,flushCnt out CNT_W  perf counters
// BEHAVIOUR
//   - Reset (clk edge with reset=1): state=RUN, lu/timeout counters=0, memErr=0, perf counters=0.
//     While reset is high, all stall/flush outputs = 0.
//   - Forwarding (combinational, all 16 regs writable, no r0 exclusion):
//     forwardAE=10 if regWriteM&&rdM==rs1E; else 01 if regWriteW&&rdW==rs1E; else 00. Same for BE with rs2E.
//   - Hazard terms:
//     memBusy = memReqM & ~memReadyM
//     luHit = regWriteE & resultSrcE==2'b01 & ((useRs1D&rdE==rs1D)|(useRs2D&rdE==rs2D))
//   - Priority, same cycle: memBusy > branchTakenE > luHit/LU_STALL.
//   - States:
//     RUN:
//       - memBusy -> stallF/D/E/M=1, flushW=1; go MEM_WAIT, tmo=1.
//       - elif branchTakenE -> flushD=1, flushE=1 this cycle only; stay RUN. A coincident luHit is discarded (wrong path).
//       - elif luHit -> stallF=stallD=1, flushE=1; LU_STALLS==1 stays RUN, else go LU_STALL, lu=LU_STALLS-1.
//     LU_STALL:
//       - stallF=stallD=1, flushE=1; lu-- each cycle; lu==1 -> RUN next.
//       - memBusy overrides to MEM_WAIT outputs; lu frozen, resumes afterwards (return state saved).
//       - branchTakenE is ignored (E holds a bubble).
//     MEM_WAIT:
//       - while memBusy: stallF/D/E/M=1, flushW=1, tmo++.
//       - memReadyM -> all stalls drop the same cycle; return to saved state (RUN or LU_STALL).
//       - tmo==MEM_TIMEOUT with memBusy still high -> memErr<=1 (sticky until reset).
//         flushD=flushE=1 and flushW=1 that cycle; M is abandoned. Go RUN.
//   - Reset mid-operation: any state returns to RUN next edge; pending bubbles dropped.
//   - Outputs are combinational from state + inputs; no added latency on stall assertion.
// CONFIGURATION
//   HAZARD_PERF_EN defined:
//     - stallCnt += 1 on every cycle with stallF=1.
//     - flushCnt += 1 on every cycle with flushD|flushE.
//     - Both counters saturate at all-ones and clear on reset.
//   HAZARD_PERF_EN undefined: stallCnt/flushCnt ports remain, tied to 0; no counter flops.
// TESTING
//   - Load-use: E ld r3 (resultSrcE=01, rdE=3), D add r4,r3 (rs1D=3, useRs1D=1), LU_STALLS=1
//     -> exactly 1 cycle stallF=stallD=flushE=1; forwardAE=01 when add reaches E.
//   - LU_STALLS=3, same hazard -> 3 consecutive bubble cycles, then RUN.
//   - Forward priority: rdM=5 and rdW=5, both regWrite, rs1E=5 -> forwardAE=10.
//     Clear regWriteM -> forwardAE=01.
//   - Branch+load-use same cycle -> flushD=flushE=1, stallF=0, no LU_STALL entry.
//   - memReqM=1, memReadyM low 4 cycles -> 4 cycles stallF/D/E/M=1 and flushW=1;
//     stalls drop in the cycle memReadyM=1; memErr=0.
//   - MEM_TIMEOUT=15, memReadyM never rises -> memErr=1 at cycle 15, pipe flushed, RUN.
//     memErr stays 1 until reset.
//   - HAZARD_PERF_EN: after the first scenario -> stallCnt=1, flushCnt=1.
//     Force CNT_W=4 with 20 stalls -> stallCnt=15.

Source files
------------

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 16-bit F/D/E/M/W core: stall/flush sequencing and E-stage forwarding.
// Optional perf counters are built when HAZARD_PERF_EN is defined; otherwise the counter ports read 0.
module hazard_sched #(
    parameter int LU_STALLS   = 1,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       rs1D,
    input  logic [3:0]       rs2D,
    input  logic             useRs1D,
    input  logic             useRs2D,
    input  logic [3:0]       rs1E,
    input  logic [3:0]       rs2E,
    input  logic [3:0]       rdE,
    input  logic             regWriteE,
    input  logic [1:0]       resultSrcE,
    input  logic             branchTakenE,
    input  logic [3:0]       rdM,
    input  logic [3:0]       rdW,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             memReqM,
    input  logic             memReadyM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t     state, state_nx;
    state_t     ret_state, ret_nx;
    logic [2:0] lu_cnt, lu_nx;
    logic [7:0] tmo_cnt, tmo_nx;
    logic       err_set;
    logic       mem_busy;
    logic       lu_hit;
    logic       s_f, s_d, s_e, s_m, f_d, f_e, f_w;

    // M has priority over W because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [3:0] rs,
                                           input logic       wr_m,
                                           input logic [3:0] rd_m,
                                           input logic       wr_w,
                                           input logic [3:0] rd_w);
        if (wr_m && rd_m == rs)
            return 2'b10;
        else if (wr_w && rd_w == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    assign forwardAE = fwd_sel(rs1E, regWriteM, rdM, regWriteW, rdW);
    assign forwardBE = fwd_sel(rs2E, regWriteM, rdM, regWriteW, rdW);

    assign mem_busy = memReqM & ~memReadyM;
    assign lu_hit   = regWriteE & (resultSrcE == 2'b01) &
                      ((useRs1D & (rdE == rs1D)) | (useRs2D & (rdE == rs2D)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            ret_state <= RUN;
            lu_cnt    <= 3'd0;
            tmo_cnt   <= 8'd0;
            memErr    <= 1'b0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            lu_cnt    <= lu_nx;
            tmo_cnt   <= tmo_nx;
            if (err_set)
                memErr <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        ret_nx   = ret_state;
        lu_nx    = lu_cnt;
        tmo_nx   = tmo_cnt;
        err_set  = 1'b0;
        s_f      = 1'b0;
        s_d      = 1'b0;
        s_e      = 1'b0;
        s_m      = 1'b0;
        f_d      = 1'b0;
        f_e      = 1'b0;
        f_w      = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    {s_f, s_d, s_e, s_m, f_w} = 5'b11111;
                    state_nx = MEM_WAIT;
                    ret_nx   = RUN;
                    tmo_nx   = 8'd1;
                end else if (branchTakenE) begin
                    // A load-use hit on the wrong path is simply dropped.
                    f_d = 1'b1;
                    f_e = 1'b1;
                end else if (lu_hit) begin
                    s_f = 1'b1;
                    s_d = 1'b1;
                    f_e = 1'b1;
                    if (LU_STALLS > 1) begin
                        state_nx = LU_STALL;
                        lu_nx    = 3'(LU_STALLS - 1);
                    end
                end
            end
            LU_STALL: begin
                if (mem_busy) begin
                    // Bubble count stays frozen and resumes once memory completes.
                    {s_f, s_d, s_e, s_m, f_w} = 5'b11111;
                    state_nx = MEM_WAIT;
                    ret_nx   = LU_STALL;
                    tmo_nx   = 8'd1;
                end else begin
                    s_f   = 1'b1;
                    s_d   = 1'b1;
                    f_e   = 1'b1;
                    lu_nx = lu_cnt - 3'd1;
                    if (lu_cnt == 3'd1)
                        state_nx = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    if (tmo_cnt == 8'(MEM_TIMEOUT)) begin
                        // Abandon the stuck access: drain D/E/W and restart clean.
                        f_d      = 1'b1;
                        f_e      = 1'b1;
                        f_w      = 1'b1;
                        err_set  = 1'b1;
                        state_nx = RUN;
                        ret_nx   = RUN;
                        lu_nx    = 3'd0;
                    end else begin
                        {s_f, s_d, s_e, s_m, f_w} = 5'b11111;
                        tmo_nx = tmo_cnt + 8'd1;
                    end
                end else begin
                    state_nx = ret_state;
                end
            end
            default: begin
                state_nx = RUN;
                ret_nx   = RUN;
            end
        endcase
    end

    assign stallF = s_f & ~reset;
    assign stallD = s_d & ~reset;
    assign stallE = s_e & ~reset;
    assign stallM = s_m & ~reset;
    assign flushD = f_d & ~reset;
    assign flushE = f_e & ~reset;
    assign flushW = f_w & ~reset;

`ifdef HAZARD_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        if (en && v != {CNT_W{1'b1}})
            return v + CNT_W'(1);
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            stallCnt <= sat_inc(stallCnt, stallF);
            flushCnt <= sat_inc(flushCnt, flushD | flushE);
        end
    end
`else
    assign stallCnt = '0;
    assign flushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: two instances (1 and 3 load-use bubbles) driven by shared stimulus,
// checked every cycle against a rule-level model plus literal spot checks.
module tb_hazard_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       useRs1D, useRs2D, regWriteE, regWriteM, regWriteW;
    logic       branchTakenE, memReqM, memReadyM;
    logic [1:0] resultSrcE;

    logic        stallF1, stallD1, stallE1, stallM1, flushD1, flushE1, flushW1, memErr1;
    logic [1:0]  fwdA1, fwdB1;
    logic [15:0] sCnt1, fCnt1;
    logic        stallF3, stallD3, stallE3, stallM3, flushD3, flushE3, flushW3, memErr3;
    logic [1:0]  fwdA3, fwdB3;
    logic [3:0]  sCnt3, fCnt3;

    hazard_sched #(.LU_STALLS(1), .MEM_TIMEOUT(15), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regWriteE(regWriteE), .resultSrcE(resultSrcE),
        .branchTakenE(branchTakenE), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memReqM(memReqM), .memReadyM(memReadyM),
        .stallF(stallF1), .stallD(stallD1), .stallE(stallE1), .stallM(stallM1),
        .flushD(flushD1), .flushE(flushE1), .flushW(flushW1),
        .forwardAE(fwdA1), .forwardBE(fwdB1), .memErr(memErr1), .stallCnt(sCnt1), .flushCnt(fCnt1)
    );

    hazard_sched #(.LU_STALLS(3), .MEM_TIMEOUT(15), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regWriteE(regWriteE), .resultSrcE(resultSrcE),
        .branchTakenE(branchTakenE), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memReqM(memReqM), .memReadyM(memReadyM),
        .stallF(stallF3), .stallD(stallD3), .stallE(stallE3), .stallM(stallM3),
        .flushD(flushD3), .flushE(flushE3), .flushW(flushW3),
        .forwardAE(fwdA3), .forwardBE(fwdB3), .memErr(memErr3), .stallCnt(sCnt3), .flushCnt(fCnt3)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: bubbles still owed, memory-wait bookkeeping, sticky error, event tallies.
    typedef struct {
        int lu_left;
        bit in_mem;
        int waited;
        bit err;
        int scnt;
        int fcnt;
    } mdl_t;

    mdl_t m1, m3;

    function automatic bit lu_hit();
        return regWriteE && resultSrcE == 2'b01 &&
               ((useRs1D && rdE == rs1D) || (useRs2D && rdE == rs2D));
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [3:0] rs);
        if (regWriteM && rdM == rs) return 2'b10;
        if (regWriteW && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Returns {stallF, stallD, stallE, stallM, flushD, flushE, flushW}.
    function automatic logic [6:0] exp_ctl(input mdl_t m, input int mt);
        bit busy;
        busy = memReqM && !memReadyM;
        if (reset) return 7'b0;
        if (m.in_mem) begin
            if (!busy) return 7'b0;
            if (m.waited == mt) return 7'b0000111;
            return 7'b1111001;
        end
        if (busy) return 7'b1111001;
        if (m.lu_left > 0) return 7'b1100010;
        if (branchTakenE) return 7'b0000110;
        if (lu_hit()) return 7'b1100010;
        return 7'b0;
    endfunction

    function automatic mdl_t next_m(input mdl_t m, input int lus, input int mt, input int cmax);
        logic [6:0] c;
        bit busy;
        mdl_t r;
        busy = memReqM && !memReadyM;
        c = exp_ctl(m, mt);
        r = m;
        if (reset) begin
            r = '{lu_left: 0, in_mem: 0, waited: 0, err: 0, scnt: 0, fcnt: 0};
            return r;
        end
        if (c[6] && r.scnt < cmax) r.scnt++;
        if ((c[2] || c[1]) && r.fcnt < cmax) r.fcnt++;
        if (m.in_mem) begin
            if (busy) begin
                if (m.waited == mt) begin
                    r.err = 1'b1;
                    r.in_mem = 1'b0;
                    r.lu_left = 0;
                end else begin
                    r.waited++;
                end
            end else begin
                r.in_mem = 1'b0;
            end
        end else if (busy) begin
            r.in_mem = 1'b1;
            r.waited = 1;
        end else if (m.lu_left > 0) begin
            r.lu_left--;
        end else if (!branchTakenE && lu_hit()) begin
            r.lu_left = lus - 1;
        end
        return r;
    endfunction

    initial begin
        m1 = '{lu_left: 0, in_mem: 0, waited: 0, err: 0, scnt: 0, fcnt: 0};
        m3 = m1;
    end

    always @(posedge clk) begin
        m1 = next_m(m1, 1, 15, 65535);
        m3 = next_m(m3, 3, 15, 15);
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ctl1", {stallF1, stallD1, stallE1, stallM1, flushD1, flushE1, flushW1}, exp_ctl(m1, 15));
            chk("ctl3", {stallF3, stallD3, stallE3, stallM3, flushD3, flushE3, flushW3}, exp_ctl(m3, 15));
            chk("fwdA1", fwdA1, exp_fwd(rs1E));
            chk("fwdB1", fwdB1, exp_fwd(rs2E));
            chk("fwdA3", fwdA3, exp_fwd(rs1E));
            chk("memErr1", memErr1, m1.err);
            chk("memErr3", memErr3, m3.err);
`ifdef HAZARD_PERF_EN
            chk("stallCnt1", sCnt1, m1.scnt);
            chk("flushCnt1", fCnt1, m1.fcnt);
            chk("stallCnt3", sCnt3, m3.scnt);
            chk("flushCnt3", fCnt3, m3.fcnt);
`else
            chk("stallCnt1", sCnt1, 0);
            chk("flushCnt3", fCnt3, 0);
`endif
        end
    end

    task automatic idle();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {useRs1D, useRs2D, regWriteE, regWriteM, regWriteW} = '0;
        {branchTakenE, memReqM, memReadyM} = '0;
        resultSrcE = 2'b00;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use();
        idle();
        regWriteE = 1'b1;
        resultSrcE = 2'b01;
        rdE = 4'd3;
        rs1D = 4'd3;
        useRs1D = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        cyc();
        started = 1'b1;
        // hazards present while reset is held: every control output stays low
        load_use();
        memReqM = 1'b1;
        branchTakenE = 1'b1;
        #2 chk("rst_stallF1", stallF1, 0);
        chk("rst_flushE3", flushE3, 0);
        cyc();
        cyc();
        idle();
        reset = 1'b0;
        #2 chk("rst_memErr1", memErr1, 0);
        cyc();

        // forwarding priority
        rs1E = 4'd5; rdM = 4'd5; rdW = 4'd5; regWriteM = 1'b1; regWriteW = 1'b1;
        #2 chk("fwd_M_first", fwdA1, 2'b10);
        cyc();
        regWriteM = 1'b0;
        rs2E = 4'd5;
        #2 chk("fwd_W_only", fwdA1, 2'b01);
        chk("fwdB_W_only", fwdB1, 2'b01);
        cyc();
        rdW = 4'd6;
        #2 chk("fwd_none", fwdA1, 2'b00);
        cyc();

        // load-use: one bubble on dut1, three on dut3
        load_use();
        #2 chk("lu_stallF1", stallF1, 1);
        chk("lu_stallD1", stallD1, 1);
        chk("lu_flushE1", flushE1, 1);
        chk("lu_stallE1", stallE1, 0);
        chk("lu_stallF3", stallF3, 1);
        cyc();
        idle();
        rs1D = 4'd3; useRs1D = 1'b1;
        #2 chk("lu2_stallF1", stallF1, 0);
        chk("lu2_stallF3", stallF3, 1);
        cyc();
        #2 chk("lu3_flushE3", flushE3, 1);
        cyc();
        #2 chk("lu4_stallF3", stallF3, 0);
        cyc();
        idle();
        rs1E = 4'd3; rdW = 4'd3; regWriteW = 1'b1;
        #2 chk("lu_fwd_W", fwdA1, 2'b01);
        cyc();

        // branch and load-use in the same cycle
        load_use();
        branchTakenE = 1'b1;
        #2 chk("br_flushD1", flushD1, 1);
        chk("br_flushE1", flushE1, 1);
        chk("br_stallF1", stallF1, 0);
        chk("br_stallF3", stallF3, 0);
        cyc();
        idle();
        #2 chk("br_next_stallF3", stallF3, 0);
        cyc();

        // four memory wait cycles, then ready
        memReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2 chk("mw_stallM1", stallM1, 1);
            chk("mw_flushW1", flushW1, 1);
            cyc();
        end
        memReadyM = 1'b1;
        #2 chk("mw_ready_stallF1", stallF1, 0);
        chk("mw_ready_stallM1", stallM1, 0);
        chk("mw_ready_flushW1", flushW1, 0);
        cyc();
        idle();
        #2 chk("mw_memErr1", memErr1, 0);
        cyc();

        // memory wait in the middle of dut3's bubble train
        load_use();
        cyc();
        idle();
        memReqM = 1'b1;
        #2 chk("lum_stallM3", stallM3, 1);
        cyc();
        cyc();
        memReadyM = 1'b1;
        #2 chk("lum_ready_stallF3", stallF3, 0);
        cyc();
        idle();
        #2 chk("lum_resume1_stallF3", stallF3, 1);
        cyc();
        #2 chk("lum_resume2_flushE3", flushE3, 1);
        cyc();
        #2 chk("lum_done_stallF3", stallF3, 0);
        cyc();

        // timeout: 15 stalled cycles, abort on the 16th
        memReqM = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #2 chk("tmo_stallE1", stallE1, 1);
            cyc();
        end
        #2 chk("tmo_abort_flushW1", flushW1, 1);
        chk("tmo_abort_flushD1", flushD1, 1);
        chk("tmo_abort_stallF1", stallF1, 0);
        chk("tmo_abort_stallM3", stallM3, 0);
        cyc();
        idle();
        #2 chk("tmo_memErr1", memErr1, 1);
        chk("tmo_memErr3", memErr3, 1);
        chk("tmo_run_stallF1", stallF1, 0);
        repeat (3) cyc();
        #2 chk("tmo_sticky", memErr1, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #2 chk("tmo_cleared", memErr1, 0);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
